cla_bist: RTL and testbench
===========================

// Module: cla_bist
// PURPOSE
//  Built-in self-test driver/checker for the registered CLA adder. Drives operand vectors
//  into the adder's A_in/B_in/Cin and reads back its registered S/Cout. Compares each result
//  against a behavioural sum and reports pass/fail, error count and vectors checked.
//  Sits beside the CLA instance and closes the loop that otherwise needs an external bench.
// PARAMETERS
//  WIDTH    4  adder operand width; must match the CLA instance
//  LATENCY  1  cycles from a_out/b_out/cin_out change to the matching s_in/cout_in (>=1)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  start      in   1           start pulse; sampled only in IDLE
//  mode       in   1           0 = diagonal sweep (A=B), 1 = exhaustive sweep; sampled with start
//  a_out      out  WIDTH       operand A to CLA A_in
//  b_out      out  WIDTH       operand B to CLA B_in
//  cin_out    out  1           carry-in to CLA Cin
//  s_in       in   WIDTH       CLA sum S
//  cout_in    in   1           CLA carry-out Cout
//  busy       out  1           high in RUN and DRAIN
//  done       out  1           one-cycle pulse at end of test
//  pass       out  1           1 when the last completed test had zero mismatches
//  err_count  out  2*WIDTH+2   saturating mismatch count of the last/current test
//  vec_count  out  2*WIDTH+2   results compared in the last/current test
// BEHAVIOUR
//  - Reset: state IDLE. All outputs and internal counters reset to 0, including pass.
//  - FSM IDLE -> RUN: on start=1. Clears err_count and vec_count and latches mode.
//  - RUN: issues one vector per cycle from index counter idx.
//    - Diagonal (idx W+1 bits): cin_out=idx[WIDTH], a_out=b_out=idx[WIDTH-1:0]; 2^(WIDTH+1) vectors.
//    - Exhaustive (idx 2W+1 bits): {cin_out,a_out,b_out}=idx; 2^(2W+1) vectors.
//    - Ordering is therefore Cin=0 first, with B as the fastest-moving field.
//  - RUN -> DRAIN: after the last vector is issued. DRAIN lasts LATENCY cycles.
//    - a_out/b_out/cin_out hold the last vector during DRAIN.
//  - DRAIN -> IDLE: done pulses for 1 cycle and pass=(err_count==0) is registered.
//    - Results hold until the next start.
//  - Expected-result pipe:
//    - Each issued vector pushes {valid, exp={carry,sum}=A+B+Cin, WIDTH+1 bits} into a LATENCY-deep shift register.
//    - When the pipe head is valid: compare {cout_in,s_in} to exp, increment vec_count, and on mismatch increment err_count.
//    - err_count saturates at all-ones.
//  - start while busy: ignored. start in the same cycle as done's IDLE entry: ignored (taken next cycle).
//  - rst mid-test: immediate abort to IDLE, pipe flushed, all outputs 0; no done pulse.
//  - Total test duration in cycles = vectors + LATENCY, from start to the done cycle inclusive of DRAIN.
// CONFIGURATION
//  CLA_BIST_ERRLOG_EN defined:
//   - Adds outputs fail_valid(1), fail_a(W), fail_b(W), fail_cin(1), fail_s(W), fail_cout(1).
//   - These capture the first mismatching vector and the observed S/Cout.
//   - fail_valid is sticky until the next start or rst.
//  CLA_BIST_ERRLOG_EN undefined: no ports or logic for the failure log; all other behaviour identical.
// STRUCTURE
//  Shared package cla_pkg:
//   - state encoding (IDLE, RUN, DRAIN)
//   - MODE_DIAG/MODE_EXH constants
//   - function cla_ref(a,b,cin) returning {carry,sum}
//  Sub-module cla_bist_exp_pipe: parameterised LATENCY-deep valid+data delay line.
//  FSM, index counter and score counters live in the top module.
// TESTING  (WIDTH=4, LATENCY=1, CLA modelled correctly unless stated)
//  1 mode=0, start pulse -> busy 33 cycles, done pulse; pass=1, err_count=0, vec_count=32.
//  2 mode=1, start pulse -> 512 vectors, done at 513 cycles; pass=1, vec_count=512.
//  3 mode=0, S[0] stuck 0 -> err_count=16 (all Cin=1 vectors), pass=0.
//    With ERRLOG: fail a=0, b=0, cin=1, s=0000, cout=0.
//  4 mode=1, Cout stuck 0 -> err_count=256 (120 with Cin=0, 136 with Cin=1), pass=0.
//  5 rst asserted at vector 10 of mode 0 -> same-cycle busy=0, a_out=0, counters 0, no done.
//    Next start reruns from vector 0 and passes.
//  6 start re-pulsed mid-RUN -> ignored: vec_count still 32, single done pulse.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the CLA adder BIST: FSM state encoding, sweep-mode
// constants and the behavioural reference sum.
package cla_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic MODE_DIAG = 1'b0;
    localparam logic MODE_EXH  = 1'b1;

    // Reference {carry,sum} for operands up to 32 bits; callers truncate the
    // result to WIDTH+1 bits so bit WIDTH is the carry-out.
    function automatic logic [32:0] cla_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

endpackage

// File: rtl/cla_bist_exp_pipe.sv
// DEPTH-stage valid+data delay line carrying expected results (and, when the
// failure log is built in, the operands) alongside the adder's own latency.
module cla_bist_exp_pipe #(
    parameter int DEPTH = 1,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [DW-1:0]    dat [DEPTH];

    // Shift every cycle; reset flushes all stages so an aborted test leaves no stale results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/cla_bist.sv
// Built-in self-test driver/checker for the registered CLA adder.
// Sweeps operand vectors (diagonal A=B or exhaustive), compares the adder's
// registered result against a behavioural sum and reports pass/error/vector counts.
// Optional failure log (first mismatching vector) enabled by CLA_BIST_ERRLOG_EN.
module cla_bist
    import cla_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               cin_out,
    input  logic [WIDTH-1:0]   s_in,
    input  logic               cout_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_count,
    output logic [2*WIDTH+1:0] vec_count
`ifdef CLA_BIST_ERRLOG_EN
   ,output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_cin,
    output logic [WIDTH-1:0]   fail_s,
    output logic               fail_cout
`endif
);

    localparam int IW = 2*WIDTH + 1;
    localparam int EW = WIDTH + 1;
    localparam int DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef CLA_BIST_ERRLOG_EN
    localparam int PW = EW + 2*WIDTH + 1;
`else
    localparam int PW = EW;
`endif

    logic [1:0]       state;
    logic             mode_q;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_n;
    logic [DCW-1:0]   drain_cnt;
    logic             start_take;
    logic             last_vec;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic             vec_cin;
    logic [EW-1:0]    exp_now;
    logic [PW-1:0]    pipe_in;
    logic             head_valid;
    logic [PW-1:0]    head_data;
    logic             mismatch;
    logic [2*WIDTH+1:0] err_next;

    assign start_take = (state == ST_IDLE) && start && !done;
    assign busy       = (state != ST_IDLE);
    assign last_vec   = (mode_q == MODE_EXH) ? (&idx) : (&idx[WIDTH:0]);
    assign exp_now    = EW'(cla_ref(32'(a_out), 32'(b_out), cin_out));

    // Next vector derived from the incremented index; B is the fastest-moving field.
    always_comb begin
        idx_n   = idx + 1'b1;
        vec_a   = idx_n[WIDTH-1:0];
        vec_b   = idx_n[WIDTH-1:0];
        vec_cin = idx_n[WIDTH];
        if (mode_q == MODE_EXH) begin
            {vec_cin, vec_a, vec_b} = idx_n;
        end
    end

    // Sequencer: IDLE -> RUN (one vector per cycle) -> DRAIN (LATENCY cycles) -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_DIAG;
            idx       <= '0;
            drain_cnt <= '0;
            a_out     <= '0;
            b_out     <= '0;
            cin_out   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_take) begin
                        state   <= ST_RUN;
                        mode_q  <= mode;
                        idx     <= '0;
                        a_out   <= '0;
                        b_out   <= '0;
                        cin_out <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_vec) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DCW'(LATENCY - 1);
                    end else begin
                        idx     <= idx_n;
                        a_out   <= vec_a;
                        b_out   <= vec_b;
                        cin_out <= vec_cin;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        // err_next includes the final result compared on this same edge.
                        pass  <= (err_next == '0);
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The vector on a_out during a RUN cycle is pushed on the following edge,
    // so the head lines up with the adder output LATENCY cycles later.
`ifdef CLA_BIST_ERRLOG_EN
    assign pipe_in = {cin_out, a_out, b_out, exp_now};
`else
    assign pipe_in = exp_now;
`endif

    cla_bist_exp_pipe #(
        .DEPTH (LATENCY),
        .DW    (PW)
    ) u_exp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state == ST_RUN),
        .in_data   (pipe_in),
        .out_valid (head_valid),
        .out_data  (head_data)
    );

    assign mismatch = head_valid && ({cout_in, s_in} != head_data[EW-1:0]);
    assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    // Score counters: cleared on an accepted start, error count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            vec_count <= '0;
        end else if (start_take) begin
            err_count <= '0;
            vec_count <= '0;
        end else begin
            err_count <= err_next;
            if (head_valid) vec_count <= vec_count + 1'b1;
        end
    end

`ifdef CLA_BIST_ERRLOG_EN
    // Capture the first mismatching vector and what the adder actually produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_s     <= '0;
            fail_cout  <= 1'b0;
        end else if (start_take) begin
            fail_valid <= 1'b0;
        end else if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_cin   <= head_data[PW-1];
            fail_a     <= head_data[EW+2*WIDTH-1:EW+WIDTH];
            fail_b     <= head_data[EW+WIDTH-1:EW];
            fail_s     <= s_in;
            fail_cout  <= cout_in;
        end
    end
`endif

endmodule

// File: tb/tb_cla_bist.sv
// Self-checking bench for cla_bist (WIDTH=4, LATENCY=1) with a registered CLA
// model that can have S[0] or Cout stuck at 0.
module tb_cla_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] a_out, b_out, s_in;
    logic       cin_out, cout_in;
    logic       busy, done, pass;
    logic [9:0] err_count, vec_count;
`ifdef CLA_BIST_ERRLOG_EN
    logic       fail_valid, fail_cin, fail_cout;
    logic [3:0] fail_a, fail_b, fail_s;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fault    = 0;   // 0 none, 1 S[0] stuck 0, 2 Cout stuck 0
    logic [4:0] cla_q;

    always #5 clk = ~clk;

    // Registered CLA model (one cycle latency).
    always @(posedge clk or posedge rst) begin
        if (rst) cla_q <= '0;
        else     cla_q <= {1'b0, a_out} + {1'b0, b_out} + {4'd0, cin_out};
    end
    assign s_in    = (fault == 1) ? {cla_q[3:1], 1'b0} : cla_q[3:0];
    assign cout_in = (fault == 2) ? 1'b0 : cla_q[4];

    cla_bist #(.WIDTH(4), .LATENCY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a_out     (a_out),
        .b_out     (b_out),
        .cin_out   (cin_out),
        .s_in      (s_in),
        .cout_in   (cout_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count)
`ifdef CLA_BIST_ERRLOG_EN
       ,.fail_valid(fail_valid),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_cin  (fail_cin),
        .fail_s    (fail_s),
        .fail_cout (fail_cout)
`endif
    );

    // Pulse start, then count busy cycles until done; also counts a stretched done.
    task automatic run_test(input logic m, output int busy_cyc, output int done_cnt, output bit timeout);
        @(negedge clk); start = 1'b1; mode = m;
        @(negedge clk); start = 1'b0;
        busy_cyc = 0; done_cnt = 0; timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin done_cnt++; timeout = 1'b0; break; end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({busy, done, pass, a_out, b_out, cin_out} !== 12'd0) begin
            n_fail++; $display("FAIL reset_outputs got busy=%b done=%b pass=%b a=%h b=%h cin=%b want all 0",
                               busy, done, pass, a_out, b_out, cin_out);
        end
        n_checks++;
        if (err_count !== 10'd0 || vec_count !== 10'd0) begin
            n_fail++; $display("FAIL reset_counts got err=%0d vec=%0d want 0 0", err_count, vec_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_diag_pass();
        int bc, dc; bit to;
        run_test(1'b0, bc, dc, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL diag_timeout got no done want done"); end
        n_checks++;
        if (bc !== 33) begin n_fail++; $display("FAIL diag_busy_cycles got %0d want 33", bc); end
        n_checks++;
        if (dc !== 1) begin n_fail++; $display("FAIL diag_done_pulses got %0d want 1", dc); end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 10'd0 || vec_count !== 10'd32) begin
            n_fail++; $display("FAIL diag_result got pass=%b err=%0d vec=%0d want 1 0 32", pass, err_count, vec_count);
        end
        n_checks++;
        if (a_out !== 4'hF || b_out !== 4'hF || cin_out !== 1'b1) begin
            n_fail++; $display("FAIL diag_last_vec_hold got a=%h b=%h cin=%b want f f 1", a_out, b_out, cin_out);
        end
    endtask

    task automatic test_exh_pass();
        int bc, dc; bit to;
        run_test(1'b1, bc, dc, to);
        n_checks++;
        if (to || bc !== 513) begin n_fail++; $display("FAIL exh_busy_cycles got %0d timeout=%b want 513", bc, to); end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 10'd0 || vec_count !== 10'd512) begin
            n_fail++; $display("FAIL exh_result got pass=%b err=%0d vec=%0d want 1 0 512", pass, err_count, vec_count);
        end
    endtask

    task automatic test_s0_stuck();
        int bc, dc; bit to;
        fault = 1;
        run_test(1'b0, bc, dc, to);
        fault = 0;
        n_checks++;
        if (to || err_count !== 10'd16 || pass !== 1'b0 || vec_count !== 10'd32) begin
            n_fail++; $display("FAIL s0_stuck got err=%0d pass=%b vec=%0d timeout=%b want 16 0 32 0",
                               err_count, pass, vec_count, to);
        end
`ifdef CLA_BIST_ERRLOG_EN
        n_checks++;
        if ({fail_valid, fail_a, fail_b, fail_cin, fail_s, fail_cout} !== {1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL s0_errlog got v=%b a=%h b=%h cin=%b s=%h cout=%b want 1 0 0 1 0 0",
                               fail_valid, fail_a, fail_b, fail_cin, fail_s, fail_cout);
        end
`endif
    endtask

    task automatic test_cout_stuck();
        int bc, dc; bit to;
        fault = 2;
        run_test(1'b1, bc, dc, to);
        fault = 0;
        n_checks++;
        if (to || err_count !== 10'd256 || pass !== 1'b0 || vec_count !== 10'd512) begin
            n_fail++; $display("FAIL cout_stuck got err=%0d pass=%b vec=%0d timeout=%b want 256 0 512 0",
                               err_count, pass, vec_count, to);
        end
    endtask

    task automatic test_rst_mid();
        int dc, bc; bit to;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        n_checks++;
        if (a_out !== 4'd10 || vec_count !== 10'd9) begin
            n_fail++; $display("FAIL rst_mid_progress got a=%0d vec=%0d want 10 9", a_out, vec_count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || a_out !== 4'd0 || vec_count !== 10'd0 || err_count !== 10'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_abort got busy=%b a=%0d vec=%0d err=%0d done=%b want 0 0 0 0 0",
                               busy, a_out, vec_count, err_count, done);
        end
        @(negedge clk); rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        n_checks++;
        if (dc !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", dc); end
        run_test(1'b0, bc, dc, to);
        n_checks++;
        if (to || pass !== 1'b1 || vec_count !== 10'd32 || bc !== 33) begin
            n_fail++; $display("FAIL rst_mid_rerun got pass=%b vec=%0d busy=%0d want 1 32 33", pass, vec_count, bc);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0;
        dc = 0; bc = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) dc++;
            if (busy) bc++;
            @(negedge clk);
        end
        n_checks++;
        if (dc !== 1 || vec_count !== 10'd32 || pass !== 1'b1 || bc !== 22) begin
            n_fail++; $display("FAIL restart_ignored got done=%0d vec=%0d pass=%b busy=%0d want 1 32 1 22",
                               dc, vec_count, pass, bc);
        end
        // start raised in the done cycle must wait one cycle before being taken
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        bc = 0;
        for (int i = 0; i < 200 && !done; i++) begin @(negedge clk); end
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_cycle got busy=%b want 0", busy); end
        @(negedge clk); start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL start_after_done got busy=%b want 1", busy); end
        for (int i = 0; i < 200 && !done; i++) begin @(negedge clk); end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 10'd32) begin
            n_fail++; $display("FAIL start_after_done_result got done=%b pass=%b vec=%0d want 1 1 32",
                               done, pass, vec_count);
        end
    endtask

    initial begin
        test_reset();
        test_diag_pass();
        test_exh_pass();
        test_s0_stuck();
        test_cout_stuck();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
